ipml_fifo_wr_arb: RTL and testbench
===================================

// Module: ipml_fifo_wr_arb
// PURPOSE
//  Round-robin burst arbiter that shares the write port of one ipml_fifo_v1_7_wr_fifo instance among c_NUM_REQ requesters.
//  Grants a burst only when the FIFO water level leaves room for a full burst plus pipeline margin, so the FIFO never overflows.
//  Sits in the wr_clk domain, in front of the FIFO; the FIFO read side is untouched.
// PARAMETERS
//  c_NUM_REQ         4    number of requesters, 2..8
//  c_DATA_WIDTH      32   word width; equals FIFO c_WR_DATA_WIDTH
//  c_WR_DEPTH_WIDTH  10   equals FIFO c_WR_DEPTH_WIDTH; FIFO depth = 2**c_WR_DEPTH_WIDTH
//  c_BURST_LEN       16   max words per grant, 1..2**c_WR_DEPTH_WIDTH-2
//  c_IDLE_TIMEOUT    8    consecutive cycles with valid low that close an open burst, 1..255
// PORTS
//  wr_clk          in   1                   single clock; all logic is on the rising edge
//  wr_rst          in   1                   asynchronous, active-high reset
//  req_valid       in   c_NUM_REQ           per-requester word valid
//  req_data        in   c_NUM_REQ*W         packed words; requester i owns bits [i*W +: W], W = c_DATA_WIDTH
//  req_last        in   c_NUM_REQ           last word of requester packet; qualified by valid&ready
//  req_ready       out  c_NUM_REQ           one-hot or zero; word accepted when valid&ready
//  fifo_wr_data    out  c_DATA_WIDTH        to FIFO wr_data
//  fifo_wr_en      out  1                   to FIFO wr_en
//  fifo_wr_full    in   1                   from FIFO wr_full
//  fifo_wr_level   in   c_WR_DEPTH_WIDTH+1  from FIFO wr_water_level
//  grant_id        out  clog2(c_NUM_REQ)    index of the current or last granted requester
//  busy            out  1                   high while in BURST
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; req_ready=0; fifo_wr_en=0; fifo_wr_data=0; grant_id=0; busy=0.
//    Reset also sets rr_ptr=0, burst_cnt=0, idle_cnt=0.
//  State machine: IDLE, BURST.
//  Room condition: fifo_wr_level <= 2**c_WR_DEPTH_WIDTH - c_BURST_LEN - 2.
//    The 2-word margin covers the registered write and the FIFO level-update lag. Compare at c_WR_DEPTH_WIDTH+2 bits.
//  IDLE: if any req_valid and room is true, pick the first valid requester starting at rr_ptr, wrapping modulo c_NUM_REQ.
//    On that edge: grant_id<=pick, busy<=1, burst_cnt<=0, idle_cnt<=0, state<=BURST.
//    Otherwise stay in IDLE. A request seen at edge k is granted at edge k+1, with ready high from edge k+1.
//  BURST: req_ready[grant_id] = ~fifo_wr_full (combinational from registered state). All other ready bits are 0.
//  Transfer (valid&ready of grant_id): on the next edge, fifo_wr_en<=1 and fifo_wr_data<=that word. Write latency is 1 cycle.
//    Otherwise fifo_wr_en<=0; fifo_wr_data holds its value.
//  Burst end, on the edge where any of the following holds:
//    a) a transfer occurs with burst_cnt==c_BURST_LEN-1;
//    b) a transfer occurs with req_last set;
//    c) idle_cnt reaches c_IDLE_TIMEOUT-1 while valid is low.
//  On burst end: state<=IDLE, busy<=0, rr_ptr<=(grant_id+1) mod c_NUM_REQ, grant_id holds.
//    Ready drops in the cycle after the end; at least 1 IDLE cycle separates bursts.
//  idle_cnt increments each BURST cycle with valid low and clears on any cycle with valid high.
//  Stalls from fifo_wr_full with valid high do not count toward the timeout.
//  A burst never exceeds c_BURST_LEN words. Overflow is impossible by the room margin; full gating is a safety net.
//  Simultaneous valid from all requesters: strict rotation, each gets at most one burst per rotation.
//  Reset mid-burst: words already written stay in the FIFO, because this block does not reset the FIFO.
//    Any word presented in the reset cycle is not accepted.
//  Only requester grant_id sees ready. Data from other requesters is ignored and never reaches the FIFO.
// TESTING
//  1 Req0 valid continuously for 40 words, last on word 40, BURST_LEN=16 -> bursts of 16/16/8; 40 fifo_wr_en pulses;
//    data in order; 1-cycle ready gap between bursts.
//  2 All 4 requesters valid continuously -> grant_id sequence 0,1,2,3,0,1...; each burst exactly 16 words;
//    FIFO words grouped per requester.
//  3 Hold fifo_wr_level=1007 (depth 1024) with req1 valid -> no grant, ready=0;
//    drop level to 1006 -> grant_id=1 and busy=1 one edge later.
//  4 Req2 asserts req_last on its 5th word -> burst ends after 5 words; rr_ptr=3; next grant goes to req3 if it is valid.
//  5 Mid-burst valid low for 7 cycles then high -> same burst continues;
//    valid low for 8 cycles -> burst closes, busy=0, rr_ptr advances.
//  6 Assert wr_rst mid-burst after 6 words -> req_ready, fifo_wr_en and busy are 0 immediately;
//    after release, req0 is granted first; FIFO holds exactly 6 words.

Source files
------------

// File: rtl/ipml_fifo_wr_arb_if.sv
// rtl/ipml_fifo_wr_arb_if.sv - requester-side write bus shared through the burst arbiter
// Ports (per requester i, word width W):
//   req_valid[i]        word valid
//   req_data[i*W +: W]  packed word
//   req_last[i]         last word of packet, qualified by valid&ready
//   req_ready[i]        one-hot or zero accept from the arbiter
// master: requester side, slave: arbiter side
interface ipml_fifo_wr_arb_if #(
  parameter int c_NUM_REQ    = 4,
  parameter int c_DATA_WIDTH = 32
);
  logic [c_NUM_REQ-1:0]              req_valid;
  logic [c_NUM_REQ*c_DATA_WIDTH-1:0] req_data;
  logic [c_NUM_REQ-1:0]              req_last;
  logic [c_NUM_REQ-1:0]              req_ready;

  modport master (output req_valid, req_data, req_last, input req_ready);
  modport slave  (input req_valid, req_data, req_last, output req_ready);
endinterface

// File: rtl/ipml_fifo_wr_arb.sv
// rtl/ipml_fifo_wr_arb.sv - round-robin burst arbiter in front of a FIFO write port
// Ports:
//   wr_clk, wr_rst  clock, asynchronous active-high reset
//   req_if          requester bus (valid/data/last in, ready out)
//   fifo_wr_data    registered write word to the FIFO
//   fifo_wr_en      registered write strobe to the FIFO
//   fifo_wr_full    FIFO full, gates ready as a safety net
//   fifo_wr_level   FIFO water level, used to admit a whole burst
//   grant_id        current or last granted requester
//   busy            high while a burst is open
module ipml_fifo_wr_arb #(
  parameter int c_NUM_REQ        = 4,
  parameter int c_DATA_WIDTH     = 32,
  parameter int c_WR_DEPTH_WIDTH = 10,
  parameter int c_BURST_LEN      = 16,
  parameter int c_IDLE_TIMEOUT   = 8
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  ipml_fifo_wr_arb_if.slave             req_if,
  output logic [c_DATA_WIDTH-1:0]       fifo_wr_data,
  output logic                          fifo_wr_en,
  input  logic                          fifo_wr_full,
  input  logic [c_WR_DEPTH_WIDTH:0]     fifo_wr_level,
  output logic [$clog2(c_NUM_REQ)-1:0]  grant_id,
  output logic                          busy
);

  localparam int ID_W   = $clog2(c_NUM_REQ);
  localparam int LVL_W  = c_WR_DEPTH_WIDTH + 2;
  localparam int BCNT_W = $clog2(c_BURST_LEN + 1);
  // Room for a full burst plus two words: one in the write register, one for level-update lag
  localparam logic [LVL_W-1:0] ROOM_MAX = LVL_W'(2**c_WR_DEPTH_WIDTH - c_BURST_LEN - 2);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state, state_nxt;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         pick;
  logic                    pick_vld;
  int                      idx;
  logic [BCNT_W-1:0]       burst_cnt;
  logic [7:0]              idle_cnt;
  logic                    room;
  logic                    g_valid;
  logic                    g_last;
  logic [c_DATA_WIDTH-1:0] g_data;
  logic                    xfer;
  logic                    burst_end;

  assign room    = {1'b0, fifo_wr_level} <= ROOM_MAX;
  assign g_valid = req_if.req_valid[grant_id];
  assign g_last  = req_if.req_last[grant_id];
  assign g_data  = req_if.req_data[int'(grant_id)*c_DATA_WIDTH +: c_DATA_WIDTH];
  assign busy    = (state == BURST);
  assign xfer    = busy & g_valid & ~fifo_wr_full;

  // Only a valid-low cycle advances the timeout; full stalls with valid high keep it at zero
  assign burst_end = busy &&
                     ((xfer && (burst_cnt == BCNT_W'(c_BURST_LEN - 1) || g_last)) ||
                      (!g_valid && idle_cnt == 8'(c_IDLE_TIMEOUT - 1)));

  // First valid requester at or after rr_ptr; scanning downward lets the smallest offset win
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = c_NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % c_NUM_REQ;
      if (req_if.req_valid[ID_W'(idx)]) begin
        pick     = ID_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_if.req_ready = '0;
    if (busy && !fifo_wr_full) req_if.req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld && room) state_nxt = BURST;
      BURST:   if (burst_end)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      grant_id     <= '0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      idle_cnt     <= '0;
    end else begin
      fifo_wr_en <= xfer;
      if (xfer) fifo_wr_data <= g_data;
      if (state == IDLE) begin
        if (pick_vld && room) begin
          grant_id  <= pick;
          burst_cnt <= '0;
          idle_cnt  <= '0;
        end
      end else begin
        if (xfer) burst_cnt <= burst_cnt + 1'b1;
        idle_cnt <= g_valid ? '0 : idle_cnt + 1'b1;
        if (burst_end)
          rr_ptr <= (grant_id == ID_W'(c_NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ipml_fifo_wr_arb.sv
// tb/tb_ipml_fifo_wr_arb.sv - self-checking bench for ipml_fifo_wr_arb
module tb_ipml_fifo_wr_arb;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int DW   = 10;
  localparam int BL   = 16;
  localparam int TO   = 8;
  localparam int ROOM = (1 << DW) - BL - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          full;
  logic [DW:0]   level;
  logic [W-1:0]  wr_data;
  logic          wr_en;
  logic [1:0]    gid;
  logic          busy;

  ipml_fifo_wr_arb_if #(.c_NUM_REQ(N), .c_DATA_WIDTH(W)) rq ();

  ipml_fifo_wr_arb #(
    .c_NUM_REQ(N), .c_DATA_WIDTH(W), .c_WR_DEPTH_WIDTH(DW),
    .c_BURST_LEN(BL), .c_IDLE_TIMEOUT(TO)
  ) dut (
    .wr_clk(clk), .wr_rst(rst), .req_if(rq),
    .fifo_wr_data(wr_data), .fifo_wr_en(wr_en), .fifo_wr_full(full),
    .fifo_wr_level(level), .grant_id(gid), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // requester sources
  int remaining[N];
  int pkt_len[N];
  int pkt_left[N];
  int seq[N];
  int vpct = 100;

  // reference model
  bit           m_busy;
  int           m_own, m_ptr, m_cnt, m_quiet;
  bit           m_wen;
  logic [W-1:0] m_wdata;
  int           acc_cnt = 0;

  // observations of the DUT
  int dut_wr = 0;
  bit prev_busy = 0;
  int grant_log[$];
  int snap[$];

  task automatic setup(input int i, input int cnt, input int plen);
    remaining[i] = cnt;
    pkt_len[i]   = plen;
    pkt_left[i]  = plen;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    snap.delete();
    dut_wr = 0;
  endtask

  function automatic int burst_len(input int k);
    return ((k + 1 < snap.size()) ? snap[k+1] : dut_wr) - snap[k];
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (remaining[i] > 0 && $urandom_range(99) < vpct) begin
        rq.req_valid[i]         = 1'b1;
        rq.req_last[i]          = (pkt_left[i] == 1);
        rq.req_data[i*W +: W]   = (i << 24) | seq[i];
      end else begin
        rq.req_valid[i]         = 1'b0;
        rq.req_last[i]          = 1'($urandom_range(1));
        rq.req_data[i*W +: W]   = $urandom;
      end
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_quiet = 0;
    m_wen = 0; m_wdata = '0;
  endtask

  task automatic src_accept(input int i);
    seq[i]++;
    remaining[i]--;
    pkt_left[i]--;
    if (pkt_left[i] == 0) pkt_left[i] = pkt_len[i];
  endtask

  // Advances the model over one rising edge using the inputs held across it
  task automatic model_step();
    logic [N-1:0] v;
    bit acc, last;
    int pick;
    v = rq.req_valid;
    if (rst) begin
      model_reset();
      return;
    end
    acc   = m_busy && !full && v[m_own];
    last  = rq.req_last[m_own];
    m_wen = acc;
    if (acc) begin
      m_wdata = rq.req_data[m_own*W +: W];
      acc_cnt++;
      src_accept(m_own);
    end
    if (!m_busy) begin
      if (v != '0 && int'(level) <= ROOM) begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && v[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        m_busy = 1; m_own = pick; m_cnt = 0; m_quiet = 0;
      end
    end else begin
      if (acc) m_cnt++;
      m_quiet = v[m_own] ? 0 : m_quiet + 1;
      if ((acc && (m_cnt == BL || last)) || m_quiet == TO) begin
        m_busy = 0;
        m_ptr  = (m_own + 1) % N;
      end
    end
  endtask

  task automatic compare();
    int exp_rdy;
    exp_rdy = (m_busy && !full) ? (1 << m_own) : 0;
    check("ready",   rq.req_ready, exp_rdy);
    check("busy",    busy,         m_busy);
    check("grant",   gid,          m_own);
    check("wr_en",   wr_en,        m_wen);
    check("wr_data", wr_data,      m_wdata);
    if (wr_en) dut_wr++;
    if (busy && !prev_busy) begin
      grant_log.push_back(int'(gid));
      snap.push_back(dut_wr);
    end
    prev_busy = busy;
  endtask

  task automatic cycle();
    drive();
    @(posedge clk);
    #1;
    model_step();
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_acc(input int target, input int limit);
    int c = 0;
    while (acc_cnt < target && c < limit) begin cycle(); c++; end
    check("wait_acc", acc_cnt >= target, 1);
  endtask

  function automatic bit drained();
    bit d = !m_busy && !m_wen;
    for (int i = 0; i < N; i++) if (remaining[i] != 0) d = 0;
    return d;
  endfunction

  task automatic wait_drain(input int limit);
    int c = 0;
    while (!drained() && c < limit) begin cycle(); c++; end
    check("wait_drain", drained(), 1);
  endtask

  initial begin
    int base;
    rst   = 1'b1;
    full  = 1'b0;
    level = '0;
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0; pkt_len[i] = 1; pkt_left[i] = 1; seq[i] = 0;
    end
    model_reset();
    run(2);
    rst = 1'b0;
    run(2);

    // all four requesters continuously: strict rotation, 16-word bursts
    clear_logs();
    for (int i = 0; i < N; i++) setup(i, 64, 1000);
    wait_drain(600);
    check("t2_nbursts", grant_log.size(), 16);
    for (int k = 0; k < grant_log.size() && k < 16; k++) begin
      check("t2_grant", grant_log[k], k % N);
      check("t2_len", burst_len(k), BL);
    end

    // one requester, 40-word packet: 16/16/8
    clear_logs();
    setup(0, 40, 40);
    wait_drain(300);
    check("t1_nbursts", grant_log.size(), 3);
    for (int k = 0; k < grant_log.size() && k < 3; k++)
      check("t1_len", burst_len(k), (k < 2) ? 16 : 8);
    check("t1_words", dut_wr, 40);

    // room threshold
    clear_logs();
    level = 11'(ROOM + 1);
    setup(1, 3, 3);
    run(10);
    check("t3_hold_busy", busy, 0);
    check("t3_hold_ready", rq.req_ready, 0);
    level = 11'(ROOM);
    cycle();
    check("t3_grant_busy", busy, 1);
    check("t3_grant_id", gid, 1);
    level = '0;
    wait_drain(100);

    // req_last on 5th word closes the burst, pointer moves past req2
    clear_logs();
    setup(2, 5, 5);
    setup(3, 4, 4);
    setup(0, 2, 2);
    wait_drain(200);
    check("t4_nbursts", grant_log.size(), 3);
    if (grant_log.size() >= 2) begin
      check("t4_first", grant_log[0], 2);
      check("t4_len", burst_len(0), 5);
      check("t4_next", grant_log[1], 3);
    end

    // idle timeout: 7 quiet cycles keep the burst, 8 close it
    clear_logs();
    setup(2, 3, 1000);
    wait_acc(acc_cnt + 3, 50);
    run(7);
    check("t5_open_busy", busy, 1);
    setup(2, 3, 1000);
    wait_acc(acc_cnt + 3, 50);
    run(8);
    check("t5_closed_busy", busy, 0);
    check("t5_one_burst", grant_log.size(), 1);
    clear_logs();
    setup(0, 1, 1000);
    setup(2, 1, 1000);
    setup(3, 1, 1000);
    wait_drain(200);
    check("t5_ptr", (grant_log.size() > 0) ? grant_log[0] : -1, 3);

    // reset mid-burst after 6 words
    clear_logs();
    setup(0, 6, 1000);
    wait_acc(acc_cnt + 6, 50);
    run(2);
    check("t6_words_before", dut_wr, 6);
    setup(0, 2, 2);
    setup(1, 2, 2);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", rq.req_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_wr_en", wr_en, 0);
    cycle();
    rst = 1'b0;
    check("t6_fifo_words", dut_wr, 6);
    base = grant_log.size();
    wait_drain(200);
    check("t6_first_after_rst", (grant_log.size() > base) ? grant_log[base] : -1, 0);

    // randomized traffic, stalls and level excursions
    vpct = 60;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if (remaining[i] == 0 && $urandom_range(7) == 0)
          setup(i, $urandom_range(1, 40), $urandom_range(1, 20));
      full  = ($urandom_range(9) == 0);
      level = ($urandom_range(3) == 0) ? 11'($urandom_range(1000, 1023)) : 11'($urandom_range(0, 999));
      cycle();
    end
    vpct  = 100;
    full  = 1'b0;
    level = '0;
    wait_drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
